// File: rtl/reset_ctrl_if.sv
// IO bus bundle for the reset controller: single-address register port.
interface reset_ctrl_if;
  logic        stb;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, we, data_in, input data_out, ack);
  modport slave  (input stb, we, data_in, output data_out, ack);
endinterface

// File: rtl/reset_ctrl.sv
// System reset sequencer: registered rst_out pulse, tick-based blanking, sticky cause and restart count.
// Optional restart counter enabled by defining RESET_CTRL_COUNT_EN.
module reset_ctrl #(
  parameter int RST_CYCLES  = 16,
  parameter int BLANK_TICKS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         wd_trig,
  output logic         rst_out,
  reset_ctrl_if.slave  bus
);

  localparam int PW = $clog2(RST_CYCLES + 1);
  localparam int TW = (BLANK_TICKS > 0) ? $clog2(BLANK_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, BLANK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pcnt, pcnt_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic [2:0]      cause, cause_nxt;
  logic            wr, sw_req, clr, trig;
  logic [7:0]      cnt_rd;
  logic            unused_bits;

  assign wr          = bus.stb & bus.we;
  assign sw_req      = wr & bus.data_in[0];
  assign clr         = wr & bus.data_in[1];
  assign trig        = (state == IDLE) & (wd_trig | sw_req);
  assign unused_bits = ^bus.data_in[31:2];

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = PULSE;
          pcnt_nxt  = '0;
        end
      end
      PULSE: begin
        // A tick in the exit cycle is not counted: tcnt starts fresh in BLANK.
        if (pcnt == PW'(RST_CYCLES - 1)) begin
          state_nxt = (BLANK_TICKS > 0) ? BLANK : IDLE;
          tcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt + PW'(1);
        end
      end
      BLANK: begin
        if (tick) begin
          if (tcnt == TW'(BLANK_TICKS - 1)) state_nxt = IDLE;
          else                              tcnt_nxt  = tcnt + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear is applied before a same-cycle trigger so the trigger's cause survives.
  always_comb begin
    cause_nxt = cause;
    if (clr)  cause_nxt = 3'b000;
    if (trig) cause_nxt = {sw_req, wd_trig, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PULSE;
      pcnt    <= '0;
      tcnt    <= '0;
      cause   <= 3'b001;
      rst_out <= 1'b1;
    end else begin
      state   <= state_nxt;
      pcnt    <= pcnt_nxt;
      tcnt    <= tcnt_nxt;
      cause   <= cause_nxt;
      rst_out <= (state_nxt == PULSE);
    end
  end

`ifdef RESET_CTRL_COUNT_EN
  logic [7:0] count, cnt_base, count_nxt;

  always_comb begin
    cnt_base  = clr ? 8'h00 : count;
    count_nxt = cnt_base;
    if (trig && cnt_base != 8'hff) count_nxt = cnt_base + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (rst) count <= 8'h00;
    else     count <= count_nxt;
  end

  assign cnt_rd = count;
`else
  assign cnt_rd = 8'h00;
`endif

  assign bus.ack      = bus.stb;
  assign bus.data_out = (bus.stb & ~bus.we) ? {16'h0000, cnt_rd, 5'b00000, cause} : 32'h0;

endmodule
